// File: rtl/cnn_pkg.sv
// Shared CNN datapath widths and post-conv FSM state encoding, common to the
// compute processor and the ReLU/max-pool writeback stage.
package cnn_pkg;
  localparam int BIT_WIDTH                  = 16;
  localparam int DATASET_DEPTH_COUNTER_BITS = 9;
  localparam int FILTER_COUNTER_BITS        = 3;

  typedef logic signed [BIT_WIDTH-1:0]                  word_t;
  typedef logic        [DATASET_DEPTH_COUNTER_BITS-1:0] col_t;
  typedef logic        [FILTER_COUNTER_BITS-1:0]        filt_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } cnn_state_e;

  // Columns actually consumed by 2:1 pooling: an odd trailing column is dropped.
  function automatic col_t pair_cols(input col_t width_len);
    return width_len & ~col_t'(1);
  endfunction
endpackage

// File: rtl/relu_maxpool_writeback_if.sv
// Control, Result RAM read port and Out RAM write port of the writeback stage.
// master = writeback block, slave = processor/RAM side.
interface relu_maxpool_writeback_if;
  import cnn_pkg::*;

  logic  start;
  col_t  width_len;
  filt_t filter_count_m1;
  logic  busy;
  logic  done_m;

  filt_t result_ram_read_address_depth;
  col_t  result_ram_read_address_width;
  logic  result_ram_read_enable;
  word_t result_ram_read_data;

  filt_t out_ram_write_address_depth;
  col_t  out_ram_write_address_width;
  logic  out_ram_write_m;
  word_t out_ram_write_data;

  modport master (
    input  start, width_len, filter_count_m1, result_ram_read_data,
    output busy, done_m,
           result_ram_read_address_depth, result_ram_read_address_width,
           result_ram_read_enable,
           out_ram_write_address_depth, out_ram_write_address_width,
           out_ram_write_m, out_ram_write_data
  );

  modport slave (
    output start, width_len, filter_count_m1, result_ram_read_data,
    input  busy, done_m,
           result_ram_read_address_depth, result_ram_read_address_width,
           result_ram_read_enable,
           out_ram_write_address_depth, out_ram_write_address_width,
           out_ram_write_m, out_ram_write_data
  );
endinterface

// File: rtl/relu_max2_unit.sv
// Combinational signed max(0, a, b); zero latency.
// No flow control: output follows inputs every cycle.
module relu_max2_unit
  import cnn_pkg::*;
#(
  parameter int W = BIT_WIDTH
) (
  input  logic signed [W-1:0] a_dat,
  input  logic signed [W-1:0] b_dat,
  output logic signed [W-1:0] max_dat
);
  logic signed [W-1:0] ab_dat;

  always_comb begin
    ab_dat  = (a_dat > b_dat) ? a_dat : b_dat;
    max_dat = ab_dat[W-1] ? '0 : ab_dat;
  end
endmodule

// File: rtl/relu_maxpool_writeback.sv
// Reads Result RAM filter by filter, ReLU + 2:1 width max-pool, writes Out RAM;
// a pair read in t,t+1 is written in t+3. No backpressure: one read per cycle.
module relu_maxpool_writeback
  import cnn_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  relu_maxpool_writeback_if.master  bus
);
  localparam col_t  COL_ONE  = col_t'(1);
  localparam filt_t FILT_ONE = filt_t'(1);

  cnn_state_e state_q, state_d;
  col_t       col_q, last_col_q, rd_pair_q, wr_width_q, start_pair_cols;
  filt_t      filt_q, last_filt_q, rd_filt_q, wr_depth_q;
  logic       rd_en, last_col, last_rd;
  logic       rd_vld_q, rd_odd_q, wr_vld_q;
  word_t      a_dat_q, max_dat, wr_dat_q;

  assign start_pair_cols = pair_cols(bus.width_len);
  assign rd_en    = (state_q == ST_READ);
  assign last_col = (col_q == last_col_q);
  assign last_rd  = last_col && (filt_q == last_filt_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (bus.start) state_d = (start_pair_cols != '0) ? ST_READ : ST_DONE;
      ST_READ:  if (last_rd) state_d = ST_DRAIN;
      // Last pair's write is the only one left once no read is in flight.
      ST_DRAIN: if (wr_vld_q && !rd_vld_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Geometry is captured at Start so later input changes cannot disturb a pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      filt_q      <= '0;
      last_col_q  <= '0;
      last_filt_q <= '0;
    end else if (state_q == ST_IDLE && bus.start) begin
      col_q       <= '0;
      filt_q      <= '0;
      last_col_q  <= start_pair_cols - COL_ONE;
      last_filt_q <= bus.filter_count_m1;
    end else if (rd_en) begin
      if (last_col) begin
        col_q  <= '0;
        filt_q <= last_rd ? '0 : filt_q + FILT_ONE;
      end else begin
        col_q  <= col_q + COL_ONE;
      end
    end
  end

  relu_max2_unit #(.W(BIT_WIDTH)) u_max2 (
    .a_dat   (a_dat_q),
    .b_dat   (bus.result_ram_read_data),
    .max_dat (max_dat)
  );

  // Read tags travel with the 1-cycle RAM latency; even column lands in a_dat_q,
  // odd column is pooled straight off the RAM bus into the write register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q   <= 1'b0;
      rd_odd_q   <= 1'b0;
      rd_pair_q  <= '0;
      rd_filt_q  <= '0;
      a_dat_q    <= '0;
      wr_vld_q   <= 1'b0;
      wr_dat_q   <= '0;
      wr_depth_q <= '0;
      wr_width_q <= '0;
    end else begin
      rd_vld_q  <= rd_en;
      rd_odd_q  <= col_q[0];
      rd_pair_q <= col_q >> 1;
      rd_filt_q <= filt_q;
      wr_vld_q  <= rd_vld_q && rd_odd_q;
      if (rd_vld_q && !rd_odd_q) a_dat_q <= bus.result_ram_read_data;
      if (rd_vld_q && rd_odd_q) begin
        wr_dat_q   <= max_dat;
        wr_depth_q <= rd_filt_q;
        wr_width_q <= rd_pair_q;
      end
    end
  end

  assign bus.result_ram_read_enable        = rd_en;
  assign bus.result_ram_read_address_depth = filt_q;
  assign bus.result_ram_read_address_width = col_q;
  assign bus.out_ram_write_m               = wr_vld_q;
  assign bus.out_ram_write_data            = wr_dat_q;
  assign bus.out_ram_write_address_depth   = wr_depth_q;
  assign bus.out_ram_write_address_width   = wr_width_q;
  assign bus.busy                          = (state_q != ST_IDLE);
  assign bus.done_m                        = (state_q == ST_DONE);
endmodule

// File: tb/tb_relu_maxpool_writeback.sv
// Bench for relu_maxpool_writeback: directed and random passes against a
// cycle-accurate reference derived from the read/write schedule rules.
module tb_relu_maxpool_writeback;
  import cnn_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  word_t mem [8][512];

  relu_maxpool_writeback_if bus();

  relu_maxpool_writeback dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Result RAM model: one-cycle read latency.
  always @(posedge clk)
    if (bus.result_ram_read_enable)
      bus.result_ram_read_data <= mem[bus.result_ram_read_address_depth][bus.result_ram_read_address_width];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic word_t ref_pool(input int f, input int k);
    int a, b, m;
    a = int'(mem[f][2*k]);
    b = int'(mem[f][2*k+1]);
    m = 0;
    if (a > m) m = a;
    if (b > m) m = b;
    return word_t'(m);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  32'(bus.busy), 0);
    chk({tag, "_done"},  32'(bus.done_m), 0);
    chk({tag, "_rden"},  32'(bus.result_ram_read_enable), 0);
    chk({tag, "_rdep"},  32'(bus.result_ram_read_address_depth), 0);
    chk({tag, "_rwid"},  32'(bus.result_ram_read_address_width), 0);
    chk({tag, "_wrm"},   32'(bus.out_ram_write_m), 0);
    chk({tag, "_wdep"},  32'(bus.out_ram_write_address_depth), 0);
    chk({tag, "_wwid"},  32'(bus.out_ram_write_address_width), 0);
    chk({tag, "_wdat"},  32'(bus.out_ram_write_data), 0);
  endtask

  task automatic fill_rand();
    for (int f = 0; f < 8; f++)
      for (int c = 0; c < 64; c++)
        mem[f][c] = word_t'($urandom);
  endtask

  // One pass; poke>0 re-asserts Start (with different geometry) in that cycle.
  task automatic run_pass(input string name, input int w, input int fm1, input int poke);
    int p, r, done_c, j, widx, f, k, nwr, exp_nwr;
    logic exp_rd, exp_wr;
    p = w / 2;
    r = (fm1 + 1) * 2 * p;
    done_c = (p > 0) ? r + 3 : 1;
    exp_nwr = (fm1 + 1) * p;
    nwr = 0;
    @(posedge clk); #1;
    bus.width_len       = col_t'(w);
    bus.filter_count_m1 = filt_t'(fm1);
    bus.start           = 1'b1;
    for (int c = 0; c <= done_c + 1; c++) begin
      @(negedge clk);
      exp_rd = (p > 0) && (c >= 1) && (c <= r);
      exp_wr = (p > 0) && (c >= 4) && (c <= r + 2) && (c % 2 == 0);
      chk($sformatf("%s_c%0d_busy", name, c), 32'(bus.busy), 32'((c >= 1) && (c <= done_c)));
      chk($sformatf("%s_c%0d_done", name, c), 32'(bus.done_m), 32'(c == done_c));
      chk($sformatf("%s_c%0d_rden", name, c), 32'(bus.result_ram_read_enable), 32'(exp_rd));
      if (exp_rd) begin
        j = c - 1;
        chk($sformatf("%s_c%0d_rdep", name, c), 32'(bus.result_ram_read_address_depth), 32'(j / (2 * p)));
        chk($sformatf("%s_c%0d_rwid", name, c), 32'(bus.result_ram_read_address_width), 32'(j % (2 * p)));
      end
      chk($sformatf("%s_c%0d_wrm", name, c), 32'(bus.out_ram_write_m), 32'(exp_wr));
      if (bus.out_ram_write_m === 1'b1) nwr++;
      if (exp_wr) begin
        widx = (c - 4) / 2;
        f = widx / p;
        k = widx % p;
        chk($sformatf("%s_c%0d_wdep", name, c), 32'(bus.out_ram_write_address_depth), 32'(f));
        chk($sformatf("%s_c%0d_wwid", name, c), 32'(bus.out_ram_write_address_width), 32'(k));
        chk($sformatf("%s_c%0d_wdat", name, c), 32'(bus.out_ram_write_data), 32'(ref_pool(f, k)));
      end
      if (c == 1) begin
        bus.start           = 1'b0;
        bus.width_len       = col_t'($urandom);
        bus.filter_count_m1 = filt_t'($urandom);
      end
      if (poke > 0 && c == poke) begin
        bus.start           = 1'b1;
        bus.width_len       = col_t'($urandom_range(2, 60));
        bus.filter_count_m1 = filt_t'($urandom);
      end
      if (poke > 0 && c == poke + 1) bus.start = 1'b0;
    end
    chk({name, "_nwrites"}, 32'(nwr), 32'(exp_nwr));
  endtask

  initial begin
    int w, fm1, r;
    bus.start = 1'b0;
    bus.width_len = '0;
    bus.filter_count_m1 = '0;
    for (int f = 0; f < 8; f++)
      for (int c = 0; c < 512; c++)
        mem[f][c] = '0;

    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    mem[0][0] = 16'sd3; mem[0][1] = -16'sd5; mem[0][2] = 16'sd7; mem[0][3] = 16'sd2;
    run_pass("basic", 4, 0, 0);

    mem[0][0] = -16'sd1; mem[0][1] = 16'sh8000; mem[0][2] = -16'sd2; mem[0][3] = -16'sd9;
    run_pass("neg", 4, 0, 0);

    fill_rand();
    run_pass("odd5", 5, 1, 0);

    run_pass("w1", 1, 3, 0);
    run_pass("w0", 0, 0, 0);

    mem[0][0] = 16'sh7FFF; mem[0][1] = 16'sh8000;
    mem[0][2] = 16'sd5;    mem[0][3] = 16'sd5;
    mem[0][4] = 16'sh8000; mem[0][5] = 16'sh0001;
    run_pass("edge", 6, 0, 0);

    fill_rand();
    run_pass("poke", 10, 2, 7);

    // Reset asserted in cycle 3 of a Width_len=8 pass.
    fill_rand();
    @(posedge clk); #1;
    bus.width_len = 9'd8; bus.filter_count_m1 = '0; bus.start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("rstmid_pre_rden", 32'(bus.result_ram_read_enable), 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1 chk_all_zero("rstmid");
    repeat (2) begin
      @(negedge clk);
      chk("rstmid_hold_wrm", 32'(bus.out_ram_write_m), 0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("rstmid_after%0d_wrm", c),  32'(bus.out_ram_write_m), 0);
      chk($sformatf("rstmid_after%0d_busy", c), 32'(bus.busy), 0);
      chk($sformatf("rstmid_after%0d_rden", c), 32'(bus.result_ram_read_enable), 0);
    end

    for (int i = 0; i < 6; i++) begin
      fill_rand();
      w   = $urandom_range(0, 40);
      fm1 = $urandom_range(0, 7);
      r   = (fm1 + 1) * 2 * (w / 2);
      run_pass($sformatf("rnd%0d", i), w, fm1, (i % 2 == 1 && r >= 3) ? $urandom_range(2, r - 1) : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
